multicycle_decoder: RTL and testbench
=====================================

# multicycle_decoder

Control-unit decoder for the multicycle ARM datapath: it replaces the single-cycle decoder with a Moore state machine that sequences fetch, decode, address, memory, execute and write-back over several clocks. It adds a memory-ready handshake, parametrised ALU-control width and optional extended data-processing ops (EOR, CMP, MOV). It sits between the instruction register and the datapath; the existing condition-logic block consumes its FlagW, PCS, NextPC, RegW, MemW and NoWrite outputs.

## Interface
- ALUCTRL_W, 3: ALUControl width, ≥3; codes zero-extended.
- EXT_OPS, 1: 1 enables EOR/CMP/MOV decode; 0 treats them as not implemented.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instr[27:26], from the instruction register.
- Funct  in  6  instr[25:20].
- Rd  in  4  instr[15:12].
- MemReady  in  1  memory completed the current access this cycle.
- IRWrite, NextPC, RegW, MemW, Branch, PCS, NoWrite, Illegal  out  1 each.
- AdrSrc  out  1  0 = PC, 1 = ALU result.
- ALUSrcA  out  2  00 = RD1, 01 = PC, 10 = ALUOut.
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result.
- ImmSrc, RegSrc  out  2 each  combinational from Op: ImmSrc = Op; RegSrc = {Op==01, Op==10}.
- ALUControl  out  ALUCTRL_W
- FlagW  out  2

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNKNOWN. Outputs are a pure function of state, plus Op/Funct/Rd/MemReady where stated.
- Default outputs: all enables 0, all selects 00, ALUOp 0.
- FETCH: AdrSrc 0, ALUSrcA 01, ALUSrcB 10, ResultSrc 10. IRWrite = NextPC = MemReady. Holds until MemReady, then goes to DECODE.
- DECODE: ALUSrcA 01, ALUSrcB 10, ResultSrc 10. Next state:
  - Op 01 → MEMADR.
  - Op 00 with Funct[5]=0 → EXECR; with Funct[5]=1 → EXECI.
  - Op 10 → BRANCH.
  - Op 11 → UNKNOWN.
- MEMADR: ALUSrcB 01. Funct[0]=1 → MEMRD; 0 → MEMWR.
- MEMRD: AdrSrc 1. Holds until MemReady, then → MEMWB.
- MEMWB: ResultSrc 01, RegW 1 → FETCH.
- MEMWR: AdrSrc 1, MemW 1 for every cycle in the state. MemReady → FETCH.
- EXECR: ALUOp 1 → ALUWB. EXECI: ALUSrcB 01, ALUOp 1 → ALUWB.
- ALUWB: ResultSrc 00, ALUOp 1, RegW = ~NoWrite → FETCH.
- BRANCH: ALUSrcB 01, ResultSrc 10, Branch 1 → FETCH.
- UNKNOWN: all enables 0, Illegal 1. Sticky until reset. Also entered on an unimplemented Funct[4:1] in EXECR/EXECI.
- ALU decode, when ALUOp=1, on Funct[4:1]:
  - Base ops: 0100 ADD → 0, 0010 SUB → 1, 0000 AND → 2, 1100 ORR → 3.
  - With EXT_OPS=1: 0001 EOR → 4, 1010 CMP → 1 with NoWrite 1, 1101 MOV → 5 (pass B).
  - When ALUOp=0, ALUControl = 0.
- FlagW[1] = ALUOp & Funct[0]. FlagW[0] = FlagW[1] & (ADD | SUB | CMP).
- PCS = ((Rd == 4'hF) & RegW) | Branch.

## Timing
- Reset asserted → state FETCH immediately, regardless of clk. The FETCH output values then apply: IRWrite = NextPC = MemReady, RegW/MemW/Branch/Illegal 0.
- Reset mid-instruction aborts the instruction: no further RegW or MemW.
- Cycles per instruction with MemReady held at 1: LDR 5, STR 4, DP 4, B 3.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemW stays asserted and AdrSrc stays stable throughout a stalled MEMWR.
- ALU-decode outputs settle in the same cycle as the Funct change; no registered outputs besides state.

## Structure
- Package mc_ctrl_pkg holds:
  - statetype enum.
  - ALU code localparams (ALU_ADD … ALU_MOV).
  - Select-encoding localparams for AdrSrc, ALUSrcA, ALUSrcB, ResultSrc.
- Sub-module alu_dec: combinational; produces ALUControl, FlagW, NoWrite and an unimplemented-op flag from ALUOp and Funct.
- Top level holds the state register, next-state logic and output decode.

## Test plan
- ADD R1,R2,R3 with S=1 and MemReady=1 → FETCH, DECODE, EXECR, ALUWB; ALUControl 0, FlagW 11, RegW 1 only in ALUWB; 4 cycles.
- LDR with MemReady low for 2 cycles in MEMRD → 7 cycles total; RegW 1 and ResultSrc 01 in MEMWB only.
- STR with MemReady low 3 cycles → MemW 1 for 4 consecutive cycles, AdrSrc 1 throughout, then FETCH.
- CMP R1,#5 (Funct 110101), EXT_OPS=1 → ALUControl 1, FlagW 11, NoWrite 1, RegW 0 in ALUWB. With EXT_OPS=0 → UNKNOWN, Illegal 1.
- B → BRANCH with Branch 1 and PCS 1. ADD with Rd=15 → PCS 1 in ALUWB.
- Reset asserted in MEMWR → state FETCH asynchronously, MemW 0 before the next edge. Op=11 → UNKNOWN held until reset.

Source files
------------

// File: rtl/multicycle_decoder_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
    } statetype;

    // ALU operation codes; CMP reuses the subtractor.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALU     = 1'b1;
    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/multicycle_decoder_if.sv
// Instruction-register / datapath side of the multicycle control unit.
interface multicycle_decoder_if #(
    parameter int ALUCTRL_W = 3
);
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic                 MemReady;
    logic                 IRWrite, NextPC, RegW, MemW, Branch, PCS, NoWrite, Illegal;
    logic                 AdrSrc;
    logic [1:0]           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
    logic [ALUCTRL_W-1:0] ALUControl;

    modport master (
        output Op, Funct, Rd, MemReady,
        input  IRWrite, NextPC, RegW, MemW, Branch, PCS, NoWrite, Illegal,
        input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW, ALUControl
    );

    modport slave (
        input  Op, Funct, Rd, MemReady,
        output IRWrite, NextPC, RegW, MemW, Branch, PCS, NoWrite, Illegal,
        output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW, ALUControl
    );
endinterface

// File: rtl/multicycle_decoder_alu_dec.sv
// Combinational ALU decode: operation code, flag-write enables, NoWrite and
// an unimplemented-operation flag from ALUOp and Funct[4:0].
module alu_dec #(
    parameter int ALUCTRL_W = 3,
    parameter bit EXT_OPS   = 1'b1
) (
    input  logic                 alu_op,
    input  logic [4:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           flag_w,
    output logic                 no_write,
    output logic                 unimpl
);
    import mc_ctrl_pkg::*;

    logic [2:0] code;
    logic       arith;

    always_comb begin
        code     = ALU_ADD;
        arith    = 1'b0;
        no_write = 1'b0;
        unimpl   = 1'b0;
        if (alu_op) begin
            case (funct[4:1])
                CMD_ADD: begin code = ALU_ADD; arith = 1'b1; end
                CMD_SUB: begin code = ALU_SUB; arith = 1'b1; end
                CMD_AND: code = ALU_AND;
                CMD_ORR: code = ALU_ORR;
                CMD_EOR: if (EXT_OPS) code = ALU_EOR; else unimpl = 1'b1;
                CMD_CMP: if (EXT_OPS) begin
                             code     = ALU_SUB;
                             arith    = 1'b1;
                             no_write = 1'b1;
                         end else begin
                             unimpl = 1'b1;
                         end
                CMD_MOV: if (EXT_OPS) code = ALU_MOV; else unimpl = 1'b1;
                default: unimpl = 1'b1;
            endcase
        end
    end

    assign alu_control = ALUCTRL_W'(code);
    assign flag_w[1]   = alu_op & funct[0];
    assign flag_w[0]   = flag_w[1] & arith;

endmodule

// File: rtl/multicycle_decoder.sv
// Moore control FSM for the multicycle ARM datapath; reset is asynchronous
// and active-low despite its name.
module multicycle_decoder #(
    parameter int ALUCTRL_W = 3,
    parameter bit EXT_OPS   = 1'b1
) (
    input logic                clk,
    input logic                reset,
    multicycle_decoder_if.slave bus
);
    import mc_ctrl_pkg::*;

    statetype             state, next_state;
    logic                 alu_op, unimpl, no_write;
    logic [1:0]           flag_w;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 ir_write, next_pc, reg_w, mem_w, branch, illegal, adr_src;
    logic [1:0]           src_a, src_b, res_src;

    alu_dec #(.ALUCTRL_W(ALUCTRL_W), .EXT_OPS(EXT_OPS)) u_alu_dec (
        .alu_op      (alu_op),
        .funct       (bus.Funct[4:0]),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .no_write    (no_write),
        .unimpl      (unimpl)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    // ALUOp kept out of the output block so RegW can depend on NoWrite
    // without forming a combinational feedback path.
    assign alu_op = (state == EXECR) || (state == EXECI) || (state == ALUWB);

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   if (bus.MemReady) next_state = DECODE;
            DECODE:
                case (bus.Op)
                    2'b00:   next_state = bus.Funct[5] ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = UNKNOWN;
                endcase
            MEMADR:  next_state = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:   if (bus.MemReady) next_state = MEMWB;
            MEMWB:   next_state = FETCH;
            MEMWR:   if (bus.MemReady) next_state = FETCH;
            EXECR,
            EXECI:   next_state = unimpl ? UNKNOWN : ALUWB;
            ALUWB,
            BRANCH:  next_state = FETCH;
            UNKNOWN: next_state = UNKNOWN;
            default: next_state = UNKNOWN;
        endcase
    end

    always_comb begin
        ir_write = 1'b0;
        next_pc  = 1'b0;
        reg_w    = 1'b0;
        mem_w    = 1'b0;
        branch   = 1'b0;
        illegal  = 1'b0;
        adr_src  = ADR_PC;
        src_a    = SRCA_RD1;
        src_b    = SRCB_RD2;
        res_src  = RES_ALUOUT;
        case (state)
            FETCH: begin
                src_a    = SRCA_PC;
                src_b    = SRCB_FOUR;
                res_src  = RES_ALU;
                ir_write = bus.MemReady;
                next_pc  = bus.MemReady;
            end
            DECODE: begin
                src_a   = SRCA_PC;
                src_b   = SRCB_FOUR;
                res_src = RES_ALU;
            end
            MEMADR:  src_b = SRCB_EXTIMM;
            MEMRD:   adr_src = ADR_ALU;
            MEMWB: begin
                res_src = RES_DATA;
                reg_w   = 1'b1;
            end
            MEMWR: begin
                adr_src = ADR_ALU;
                mem_w   = 1'b1;
            end
            EXECI:   src_b = SRCB_EXTIMM;
            ALUWB: begin
                res_src = RES_ALUOUT;
                reg_w   = ~no_write;
            end
            BRANCH: begin
                src_b   = SRCB_EXTIMM;
                res_src = RES_ALU;
                branch  = 1'b1;
            end
            UNKNOWN: illegal = 1'b1;
            default: ;
        endcase
    end

    assign bus.IRWrite    = ir_write;
    assign bus.NextPC     = next_pc;
    assign bus.RegW       = reg_w;
    assign bus.MemW       = mem_w;
    assign bus.Branch     = branch;
    assign bus.Illegal    = illegal;
    assign bus.NoWrite    = no_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ResultSrc  = res_src;
    assign bus.ALUControl = alu_control;
    assign bus.FlagW      = flag_w;
    assign bus.PCS        = ((bus.Rd == 4'hF) & reg_w) | branch;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_decoder.sv
// Instruction-level reference bench for multicycle_decoder, covering the
// extended-op build (ALUControl 3 bits) and the base build (4 bits).
module tb_multicycle_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mem_ready;
    bit         use_b;

    multicycle_decoder_if #(.ALUCTRL_W(3)) bus_e ();
    multicycle_decoder_if #(.ALUCTRL_W(4)) bus_b ();

    assign bus_e.Op = op;  assign bus_e.Funct = funct;  assign bus_e.Rd = rd;  assign bus_e.MemReady = mem_ready;
    assign bus_b.Op = op;  assign bus_b.Funct = funct;  assign bus_b.Rd = rd;  assign bus_b.MemReady = mem_ready;

    multicycle_decoder #(.ALUCTRL_W(3), .EXT_OPS(1'b1)) dut_e (.clk(clk), .reset(reset), .bus(bus_e));
    multicycle_decoder #(.ALUCTRL_W(4), .EXT_OPS(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic [15:0] en_e, en_b, sel_e, sel_b, alu_e, alu_b, obs_en, obs_sel, obs_alu;
    assign en_e  = {8'h0, bus_e.IRWrite, bus_e.NextPC, bus_e.RegW, bus_e.MemW,
                    bus_e.Branch, bus_e.PCS, bus_e.NoWrite, bus_e.Illegal};
    assign en_b  = {8'h0, bus_b.IRWrite, bus_b.NextPC, bus_b.RegW, bus_b.MemW,
                    bus_b.Branch, bus_b.PCS, bus_b.NoWrite, bus_b.Illegal};
    assign sel_e = {5'h0, bus_e.AdrSrc, bus_e.ALUSrcA, bus_e.ALUSrcB, bus_e.ResultSrc, bus_e.ImmSrc, bus_e.RegSrc};
    assign sel_b = {5'h0, bus_b.AdrSrc, bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ResultSrc, bus_b.ImmSrc, bus_b.RegSrc};
    assign alu_e = {11'h0, bus_e.ALUControl, bus_e.FlagW};
    assign alu_b = {10'h0, bus_b.ALUControl, bus_b.FlagW};
    assign obs_en  = use_b ? en_b  : en_e;
    assign obs_sel = use_b ? sel_b : sel_e;
    assign obs_alu = use_b ? alu_b : alu_e;

    typedef struct {
        bit       mr, irw, npc, regw, memw, br, ill, adr, nw, pcs;
        bit [1:0] sa, sb, rs, fw;
        bit [3:0] code;
    } exp_t;

    exp_t     q[$];
    int       n_checks = 0;
    int       n_errors = 0;
    bit [1:0] cur_op;
    bit [5:0] cur_funct;
    bit [3:0] cur_rd;
    bit       cur_ext;
    bit       need_reset;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Data-processing semantics: ALU code, NoWrite, implemented, flag-setting arithmetic.
    task automatic alu_ref(input bit [5:0] f, input bit ext,
                           output bit [3:0] code, output bit nw, output bit ok, output bit ar);
        code = 4'd0; nw = 1'b0; ok = 1'b1; ar = 1'b0;
        case (f[4:1])
            4'b0100: begin code = 4'd0; ar = 1'b1; end
            4'b0010: begin code = 4'd1; ar = 1'b1; end
            4'b0000: code = 4'd2;
            4'b1100: code = 4'd3;
            4'b0001: if (ext) code = 4'd4; else ok = 1'b0;
            4'b1010: if (ext) begin code = 4'd1; nw = 1'b1; ar = 1'b1; end else ok = 1'b0;
            4'b1101: if (ext) code = 4'd5; else ok = 1'b0;
            default: ok = 1'b0;
        endcase
    endtask

    function automatic exp_t blank();
        exp_t e = '{default: 0};
        e.mr = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic emit(input exp_t e_in, input bit aluop);
        exp_t     e = e_in;
        bit [3:0] c;
        bit       nw, ok, ar;
        if (aluop) begin
            alu_ref(cur_funct, cur_ext, c, nw, ok, ar);
            e.code  = ok ? c : 4'd0;
            e.nw    = nw;
            e.fw[1] = cur_funct[0];
            e.fw[0] = cur_funct[0] & ar;
        end
        e.pcs = (e.regw && cur_rd == 4'hF) || e.br;
        q.push_back(e);
    endtask

    task automatic push_unknown();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = blank();
            e.ill = 1'b1;
            emit(e, 1'b0);
        end
        need_reset = 1'b1;
    endtask

    // Expected cycle-by-cycle outputs for one instruction; fst/mst are the
    // number of MemReady-low cycles in the fetch and data access.
    task automatic plan(input bit [1:0] o, input bit [5:0] f, input bit [3:0] r,
                        input bit ext, input int fst, input int mst);
        exp_t     e;
        bit [3:0] c;
        bit       nw, ok, ar;
        cur_op = o; cur_funct = f; cur_rd = r; cur_ext = ext; need_reset = 1'b0;
        for (int i = 0; i <= fst; i++) begin
            e = blank();
            e.mr = (i == fst); e.irw = e.mr; e.npc = e.mr;
            e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10;
            emit(e, 1'b0);
        end
        e = blank(); e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10;
        emit(e, 1'b0);
        case (o)
            2'b01: begin
                e = blank(); e.sb = 2'b01;
                emit(e, 1'b0);
                for (int i = 0; i <= mst; i++) begin
                    e = blank(); e.mr = (i == mst); e.adr = 1'b1; e.memw = !f[0];
                    emit(e, 1'b0);
                end
                if (f[0]) begin
                    e = blank(); e.rs = 2'b01; e.regw = 1'b1;
                    emit(e, 1'b0);
                end
            end
            2'b00: begin
                alu_ref(f, ext, c, nw, ok, ar);
                e = blank(); e.sb = f[5] ? 2'b01 : 2'b00;
                emit(e, 1'b1);
                if (!ok) push_unknown();
                else begin
                    e = blank(); e.rs = 2'b00; e.regw = !nw;
                    emit(e, 1'b1);
                end
            end
            2'b10: begin
                e = blank(); e.sb = 2'b01; e.rs = 2'b10; e.br = 1'b1;
                emit(e, 1'b0);
            end
            default: push_unknown();
        endcase
    endtask

    task automatic check_cycle(input exp_t e);
        check_eq("en",  obs_en,  {8'h0, e.irw, e.npc, e.regw, e.memw, e.br, e.pcs, e.nw, e.ill});
        check_eq("sel", obs_sel, {5'h0, e.adr, e.sa, e.sb, e.rs, op, op == 2'b01, op == 2'b10});
        check_eq("alu", obs_alu, {10'h0, e.code, e.fw});
    endtask

    // Called just after a falling edge; finishes well before the next rising edge.
    task automatic do_reset();
        logic mr;
        #1 reset = 1'b0;
        mr = 1'($urandom_range(0, 1));
        mem_ready = mr;
        #1;
        check_eq("rst_en",  obs_en,  {8'h0, mr, mr, 6'b0});
        check_eq("rst_sel", obs_sel, {5'h0, 1'b0, 2'b01, 2'b10, 2'b10, op, op == 2'b01, op == 2'b10});
        mem_ready = 1'b0;
        #1 reset = 1'b1;
    endtask

    task automatic run(input int abort_at);
        exp_t e;
        int   idx = 0;
        bit   aborted = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            if (idx == 0) begin
                op = cur_op; funct = cur_funct; rd = cur_rd;
            end
            mem_ready = e.mr;
            @(negedge clk);
            check_cycle(e);
            if (idx == abort_at) begin
                do_reset();
                q.delete();
                aborted = 1'b1;
            end
            idx++;
        end
        if (need_reset && !aborted) do_reset();
    endtask

    task automatic random_instrs(input bit ext, input int n);
        bit [1:0] o;
        for (int i = 0; i < n; i++) begin
            o = 2'($urandom_range(0, 3));
            if (o == 2'b11 && $urandom_range(0, 2) != 0) o = 2'b00;
            plan(o, 6'($urandom), 4'($urandom), ext, $urandom_range(0, 2), $urandom_range(0, 2));
            run(($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1);
        end
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; op = 2'b00; funct = 6'h0; rd = 4'h0; use_b = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        plan(2'b00, 6'b001001, 4'd1,  1'b1, 0, 0); run(-1);  // ADD S=1
        plan(2'b01, 6'b011001, 4'd2,  1'b1, 0, 2); run(-1);  // LDR, 2 stalls
        plan(2'b01, 6'b011000, 4'd3,  1'b1, 0, 3); run(-1);  // STR, 3 stalls
        plan(2'b00, 6'b110101, 4'd1,  1'b1, 0, 0); run(-1);  // CMP #5
        plan(2'b00, 6'b111010, 4'd4,  1'b1, 1, 0); run(-1);  // MOV imm
        plan(2'b00, 6'b000010, 4'd5,  1'b1, 0, 0); run(-1);  // EOR
        plan(2'b10, 6'b000000, 4'd0,  1'b1, 0, 0); run(-1);  // B
        plan(2'b00, 6'b001000, 4'hF,  1'b1, 1, 0); run(-1);  // ADD to PC
        plan(2'b11, 6'b000000, 4'd0,  1'b1, 0, 0); run(-1);  // Op 11
        plan(2'b01, 6'b011000, 4'd6,  1'b1, 0, 3); run(4);   // reset mid-MEMWR
        plan(2'b00, 6'b000100, 4'd7,  1'b1, 0, 0); run(-1);
        random_instrs(1'b1, 120);

        use_b = 1'b1;
        @(negedge clk);
        do_reset();
        plan(2'b00, 6'b110101, 4'd1,  1'b0, 0, 0); run(-1);  // CMP in base build -> UNKNOWN
        plan(2'b00, 6'b000010, 4'd2,  1'b0, 0, 0); run(-1);  // EOR in base build -> UNKNOWN
        plan(2'b00, 6'b001001, 4'hF,  1'b0, 0, 0); run(-1);
        plan(2'b01, 6'b011001, 4'd3,  1'b0, 2, 1); run(-1);
        random_instrs(1'b0, 120);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
